// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and constants for the button conditioner
package button_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_t;

    localparam int DB_CYCLES_20MS = 2_000_000;

    // A single-cycle debounce still needs a 1-bit counter to hold a value.
    function automatic int db_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - synchroniser, debounce FSM and edge pulses for one button
module debounce_channel
    import button_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_20MS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall
);

    localparam int CNT_W = db_cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic            s1_q, s2_q;
    db_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            ZERO: begin
                if (s2_q) begin
                    state_d = WAIT1;
                    cnt_d   = '0;
                end
            end
            WAIT1: begin
                if (!s2_q) begin
                    state_d = ZERO;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ONE;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ONE: begin
                if (!s2_q) begin
                    state_d = WAIT0;
                    cnt_d   = '0;
                end
            end
            WAIT0: begin
                if (s2_q) begin
                    state_d = ONE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ZERO;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ZERO;
        endcase
        level_d = (state_d == ONE) || (state_d == WAIT0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= ZERO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= btn_raw;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - N_BTN independent debounced button channels
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BTN     = 3,
    parameter int DB_CYCLES = DB_CYCLES_20MS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_channel #(
            .DB_CYCLES(DB_CYCLES)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_raw  (btn_raw[i]),
            .btn_level(btn_level[i]),
            .btn_rise (btn_rise[i]),
            .btn_fall (btn_fall[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner
module tb_button_conditioner;

    localparam int N  = 3;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level, btn_rise, btn_fall;

    button_conditioner #(.N_BTN(N), .DB_CYCLES(DB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           at;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] level;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse expected 'dc' edges after the current one.
    task automatic expect_ev(input int dc, input logic [N-1:0] r, input logic [N-1:0] f,
                             input logic [N-1:0] l);
        exp_t e;
        e.at = cyc + dc; e.rise = r; e.fall = f; e.level = l;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (btn_rise !== '0 || btn_fall !== '0) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_pulse: rise %b fall %b at cycle %0d, none expected",
                             btn_rise, btn_fall, cyc);
                end else begin
                    e = sb.pop_front();
                    check("pulse_cycle", cyc, e.at);
                    check("pulse_rise", 32'(btn_rise), 32'(e.rise));
                    check("pulse_fall", 32'(btn_fall), 32'(e.fall));
                    check("pulse_level", 32'(btn_level), 32'(e.level));
                end
            end
        end
    end

    logic seq [6];

    initial begin
        seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        tick(3);
        check("reset_level", 32'(btn_level), 0);
        check("reset_rise", 32'(btn_rise), 0);
        check("reset_fall", 32'(btn_fall), 0);
        rst_n = 1'b1;
        tick(3);

        // Clean press and release on channel 0.
        btn_raw = 3'b001;
        expect_ev(7, 3'b001, 3'b000, 3'b001);
        tick(12);
        check("press_level_held", 32'(btn_level), 32'h1);
        btn_raw = 3'b000;
        expect_ev(7, 3'b000, 3'b001, 3'b000);
        tick(12);

        // Three-cycle glitch on channel 1 must be swallowed.
        btn_raw = 3'b010;
        tick(3);
        btn_raw = 3'b000;
        tick(10);
        check("glitch_level", 32'(btn_level), 0);

        // Bouncing press: acceptance restarts from the last 0->1.
        expect_ev(12, 3'b001, 3'b000, 3'b001);
        for (int i = 0; i < 6; i++) begin
            btn_raw[0] = seq[i];
            tick();
        end
        tick(12);
        btn_raw = 3'b000;
        expect_ev(7, 3'b000, 3'b001, 3'b000);
        tick(12);

        // Reset during WAIT1 on channel 2 discards the pending press.
        btn_raw = 3'b100;
        expect_ev(11, 3'b100, 3'b000, 3'b100);
        tick(3);
        rst_n = 1'b0;
        tick();
        check("midreset_level", 32'(btn_level), 0);
        check("midreset_rise", 32'(btn_rise), 0);
        check("midreset_fall", 32'(btn_fall), 0);
        rst_n = 1'b1;
        tick(12);
        btn_raw = 3'b000;
        expect_ev(7, 3'b000, 3'b100, 3'b000);
        tick(12);

        // Simultaneous press/release on channels 0 and 2.
        btn_raw = 3'b101;
        expect_ev(7, 3'b101, 3'b000, 3'b101);
        tick(12);
        check("dual_level_held", 32'(btn_level), 32'h5);
        btn_raw = 3'b000;
        expect_ev(7, 3'b000, 3'b101, 3'b000);
        tick(12);

        check("scoreboard_drained", sb.size(), 0);
        check("final_level", 32'(btn_level), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
